// File: rtl/part_sram_sync.sv
// Parametrised synchronous SRAM: per-bit write mask, stored word parity,
// selectable read latency / read-during-write mode and a post-reset clear sweep.
module part_sram_sync #(
   parameter int WIDTH   = 1,
   parameter int AWIDTH  = 12,
   parameter int RD_LAT  = 1,
   parameter int WR_THRU = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ce_n,
   input  logic              we_n,
   input  logic [AWIDTH-1:0] addr,
   input  logic [WIDTH-1:0]  di,
   input  logic [WIDTH-1:0]  wmask,
   input  logic              inject_perr,
   output logic [WIDTH-1:0]  dout,
   output logic              do_valid,
   output logic              perr,
   output logic              busy
);

   localparam int DEPTH = 2**AWIDTH;

   typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

   state_t            state_reg;
   logic [AWIDTH-1:0] cnt_reg;

   // Word layout: parity in the top bit, data below it.
   logic [WIDTH:0]    mem [DEPTH];

   logic [WIDTH:0]    old_word;
   logic [WIDTH:0]    new_word;
   logic [WIDTH:0]    rd_word;
   logic [WIDTH-1:0]  merged;
   logic              access;
   logic              wr_access;
   logic              mem_we;
   logic [AWIDTH-1:0] mem_addr;
   logic [WIDTH:0]    mem_wdata;
   logic              out_load;
   logic [WIDTH:0]    out_word;

   // The full merged word is needed for parity, so the old word is read in the
   // same cycle as the masked write.
   assign old_word = mem[addr];

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_merge
         assign merged[gi] = wmask[gi] ? di[gi] : old_word[gi];
      end
   endgenerate

   assign new_word  = {(^merged) ^ inject_perr, merged};
   assign access    = (state_reg == READY) && !ce_n;
   assign wr_access = access && !we_n;
   assign rd_word   = (wr_access && (WR_THRU != 0)) ? new_word : old_word;

   assign mem_we    = (state_reg == CLEAR) || wr_access;
   assign mem_addr  = (state_reg == CLEAR) ? cnt_reg : addr;
   assign mem_wdata = (state_reg == CLEAR) ? '0 : new_word;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= CLEAR;
         cnt_reg   <= '0;
         busy      <= 1'b1;
      end else begin
         case (state_reg)
            CLEAR: begin
               cnt_reg <= cnt_reg + 1'b1;
               if (cnt_reg == {AWIDTH{1'b1}}) begin
                  state_reg <= READY;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state_reg <= READY;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic           p1_valid_reg;
         logic [WIDTH:0] p1_word_reg;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               p1_valid_reg <= 1'b0;
               p1_word_reg  <= '0;
            end else begin
               p1_valid_reg <= access;
               if (access) begin
                  p1_word_reg <= rd_word;
               end
            end
         end

         assign out_load = p1_valid_reg;
         assign out_word = p1_word_reg;
      end else begin : g_lat1
         assign out_load = access;
         assign out_word = rd_word;
      end
   endgenerate

   // perr is a strobe qualified by do_valid; dout holds between reads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dout     <= '0;
         do_valid <= 1'b0;
         perr     <= 1'b0;
      end else begin
         do_valid <= out_load;
         perr     <= out_load && ((^out_word[WIDTH-1:0]) != out_word[WIDTH]);
         if (out_load) begin
            dout <= out_word[WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_part_sram_sync.sv
// Bench for part_sram_sync: two instances (RD_LAT=1/WR_THRU=1 and RD_LAT=2/WR_THRU=0)
// share stimulus and are checked against an array-level reference model.
module tb_part_sram_sync;

   localparam int W     = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          ce_n;
   logic          we_n;
   logic [AW-1:0] addr;
   logic [W-1:0]  di;
   logic [W-1:0]  wmask;
   logic          inject_perr;
   logic [W-1:0]  dout_a, dout_b;
   logic          valid_a, valid_b, perr_a, perr_b, busy_a, busy_b;

   always #5 clk = ~clk;

   part_sram_sync #(.WIDTH(W), .AWIDTH(AW), .RD_LAT(1), .WR_THRU(1)) u_a (
      .clk(clk), .reset_n(reset_n), .ce_n(ce_n), .we_n(we_n), .addr(addr),
      .di(di), .wmask(wmask), .inject_perr(inject_perr),
      .dout(dout_a), .do_valid(valid_a), .perr(perr_a), .busy(busy_a));

   part_sram_sync #(.WIDTH(W), .AWIDTH(AW), .RD_LAT(2), .WR_THRU(0)) u_b (
      .clk(clk), .reset_n(reset_n), .ce_n(ce_n), .we_n(we_n), .addr(addr),
      .di(di), .wmask(wmask), .inject_perr(inject_perr),
      .dout(dout_b), .do_valid(valid_b), .perr(perr_b), .busy(busy_b));

   typedef struct packed {
      logic         v;
      logic [W-1:0] d;
      logic         p;
   } ent_t;

   logic [W-1:0] m_data [DEPTH];
   logic         m_par  [DEPTH];
   int           sweep_left;
   ent_t         cur_a, cur_b, prev_b, exp_a, exp_b;
   int           n_tests = 0;
   int           n_fail  = 0;

   task automatic drive(input logic ce, input logic we, input logic [AW-1:0] a,
                        input logic [W-1:0] d, input logic [W-1:0] m, input logic inj);
      logic [W-1:0] old_w, new_w;
      logic         old_p, new_p;
      ce_n = ce; we_n = we; addr = a; di = d; wmask = m; inject_perr = inj;
      cur_a = '0;
      cur_b = '0;
      if (sweep_left == 0 && !ce) begin
         old_w = m_data[a];
         old_p = m_par[a];
         cur_b.v = 1'b1;
         cur_b.d = old_w;
         cur_b.p = ((^old_w) != old_p);
         if (!we) begin
            new_w = (old_w & ~m) | (d & m);
            new_p = (^new_w) ^ inj;
            m_data[a] = new_w;
            m_par[a]  = new_p;
            cur_a.v = 1'b1;
            cur_a.d = new_w;
            cur_a.p = ((^new_w) != new_p);
         end else begin
            cur_a = cur_b;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      if (reset_n && sweep_left > 0) sweep_left--;
      exp_a.v = cur_a.v;
      if (cur_a.v) begin exp_a.d = cur_a.d; exp_a.p = cur_a.p; end
      exp_b.v = prev_b.v;
      if (prev_b.v) begin exp_b.d = prev_b.d; exp_b.p = prev_b.p; end
      prev_b = cur_b;
      cur_a = '0;
      cur_b = '0;
      ce_n = 1'b1; we_n = 1'b1; inject_perr = 1'b0;
   endtask

   task automatic assert_reset();
      reset_n = 1'b0;
      sweep_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) begin
         m_data[i] = '0;
         m_par[i]  = 1'b0;
      end
      cur_a = '0; cur_b = '0; prev_b = '0; exp_a = '0; exp_b = '0;
      ce_n = 1'b1; we_n = 1'b1; inject_perr = 1'b0;
   endtask

   task automatic release_and_count(output int cycles);
      reset_n = 1'b1;
      cycles = 0;
      while (busy_a === 1'b1 && cycles < 100) begin
         tick();
         cycles++;
      end
   endtask

   task automatic test_reset();
      int cycles;
      @(negedge clk);
      assert_reset();
      #1;
      n_tests++;
      if ({dout_a, valid_a, perr_a, busy_a} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_a: got d=%h v=%b p=%b busy=%b expected d=00 v=0 p=0 busy=1",
                  dout_a, valid_a, perr_a, busy_a);
      end
      n_tests++;
      if ({dout_b, valid_b, perr_b, busy_b} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_b: got d=%h v=%b p=%b busy=%b expected d=00 v=0 p=0 busy=1",
                  dout_b, valid_b, perr_b, busy_b);
      end
      tick();
      tick();
      release_and_count(cycles);
      n_tests++;
      if (cycles != 16) begin
         n_fail++;
         $display("FAIL sweep_len: got %0d cycles expected 16", cycles);
      end
      n_tests++;
      if (busy_b !== 1'b0) begin
         n_fail++;
         $display("FAIL sweep_busy_b: got %b expected 0", busy_b);
      end
   endtask

   task automatic test_clear_read();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, 1'b1, AW'(i), 8'h00, 8'h00, 1'b0);
         tick();
         n_tests++;
         if ({valid_a, dout_a, perr_a} !== {1'b1, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL clear_a addr %0d: got v=%b d=%h p=%b expected v=1 d=00 p=0",
                     i, valid_a, dout_a, perr_a);
         end
         if (i > 0) begin
            n_tests++;
            if ({valid_b, dout_b, perr_b} !== {1'b1, 8'h00, 1'b0}) begin
               n_fail++;
               $display("FAIL clear_b addr %0d: got v=%b d=%h p=%b expected v=1 d=00 p=0",
                        i - 1, valid_b, dout_b, perr_b);
            end
         end
      end
      tick();
      n_tests++;
      if ({valid_a, valid_b, dout_b} !== {1'b0, 1'b1, 8'h00}) begin
         n_fail++;
         $display("FAIL clear_tail: got va=%b vb=%b db=%h expected va=0 vb=1 db=00",
                  valid_a, valid_b, dout_b);
      end
      tick();
   endtask

   task automatic test_write_read();
      drive(1'b0, 1'b0, 4'd5, 8'hA5, 8'hFF, 1'b0);
      tick();
      drive(1'b0, 1'b1, 4'd5, 8'h00, 8'h00, 1'b0);
      tick();
      n_tests++;
      if ({valid_a, dout_a, perr_a} !== {1'b1, 8'hA5, 1'b0}) begin
         n_fail++;
         $display("FAIL wr_rd_a: got v=%b d=%h p=%b expected v=1 d=a5 p=0", valid_a, dout_a, perr_a);
      end
      n_tests++;
      if ({valid_b, dout_b} !== {1'b1, 8'h00}) begin
         n_fail++;
         $display("FAIL wr_old_b: got v=%b d=%h expected v=1 d=00", valid_b, dout_b);
      end
      tick();
      n_tests++;
      if ({valid_a, dout_a} !== {1'b0, 8'hA5}) begin
         n_fail++;
         $display("FAIL hold_a: got v=%b d=%h expected v=0 d=a5", valid_a, dout_a);
      end
      n_tests++;
      if ({valid_b, dout_b, perr_b} !== {1'b1, 8'hA5, 1'b0}) begin
         n_fail++;
         $display("FAIL wr_rd_b: got v=%b d=%h p=%b expected v=1 d=a5 p=0", valid_b, dout_b, perr_b);
      end
      tick();
   endtask

   task automatic test_mask();
      drive(1'b0, 1'b0, 4'd5, 8'h00, 8'h0F, 1'b0);
      tick();
      drive(1'b0, 1'b1, 4'd5, 8'h00, 8'h00, 1'b0);
      tick();
      n_tests++;
      if ({valid_a, dout_a, perr_a} !== {1'b1, 8'hA0, 1'b0}) begin
         n_fail++;
         $display("FAIL mask_a: got v=%b d=%h p=%b expected v=1 d=a0 p=0", valid_a, dout_a, perr_a);
      end
      tick();
      n_tests++;
      if ({valid_b, dout_b, perr_b} !== {1'b1, 8'hA0, 1'b0}) begin
         n_fail++;
         $display("FAIL mask_b: got v=%b d=%h p=%b expected v=1 d=a0 p=0", valid_b, dout_b, perr_b);
      end
      tick();
   endtask

   task automatic test_rdw();
      drive(1'b0, 1'b0, 4'd3, 8'h11, 8'hFF, 1'b0);
      tick(); tick(); tick();
      drive(1'b0, 1'b0, 4'd3, 8'h22, 8'hFF, 1'b0);
      tick();
      n_tests++;
      if ({valid_a, dout_a} !== {1'b1, 8'h22}) begin
         n_fail++;
         $display("FAIL rdw_thru_a: got v=%b d=%h expected v=1 d=22", valid_a, dout_a);
      end
      tick();
      n_tests++;
      if ({valid_b, dout_b} !== {1'b1, 8'h11}) begin
         n_fail++;
         $display("FAIL rdw_old_b: got v=%b d=%h expected v=1 d=11", valid_b, dout_b);
      end
      drive(1'b0, 1'b1, 4'd3, 8'h00, 8'h00, 1'b0);
      tick();
      n_tests++;
      if ({valid_a, dout_a} !== {1'b1, 8'h22}) begin
         n_fail++;
         $display("FAIL rdw_after_a: got v=%b d=%h expected v=1 d=22", valid_a, dout_a);
      end
      tick();
      n_tests++;
      if ({valid_b, dout_b} !== {1'b1, 8'h22}) begin
         n_fail++;
         $display("FAIL rdw_after_b: got v=%b d=%h expected v=1 d=22", valid_b, dout_b);
      end
      tick();
   endtask

   task automatic test_parity();
      for (int k = 0; k < 2; k++) begin
         logic inj;
         inj = (k == 0);
         drive(1'b0, 1'b0, 4'd7, 8'h3C, 8'hFF, inj);
         tick();
         drive(1'b0, 1'b1, 4'd7, 8'h00, 8'h00, 1'b0);
         tick();
         n_tests++;
         if ({valid_a, dout_a, perr_a} !== {1'b1, 8'h3C, inj}) begin
            n_fail++;
            $display("FAIL parity_a inj=%b: got v=%b d=%h p=%b expected v=1 d=3c p=%b",
                     inj, valid_a, dout_a, perr_a, inj);
         end
         tick();
         n_tests++;
         if ({valid_b, dout_b, perr_b} !== {1'b1, 8'h3C, inj}) begin
            n_fail++;
            $display("FAIL parity_b inj=%b: got v=%b d=%h p=%b expected v=1 d=3c p=%b",
                     inj, valid_b, dout_b, perr_b, inj);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      int cycles;
      drive(1'b0, 1'b1, 4'd7, 8'h00, 8'h00, 1'b0);
      tick();
      n_tests++;
      if ({valid_a, dout_a} !== {1'b1, 8'h3C}) begin
         n_fail++;
         $display("FAIL pend_rd_a: got v=%b d=%h expected v=1 d=3c", valid_a, dout_a);
      end
      assert_reset();
      #1;
      n_tests++;
      if ({valid_a, valid_b, busy_b} !== {1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL pend_rst: got va=%b vb=%b busy=%b expected va=0 vb=0 busy=1",
                  valid_a, valid_b, busy_b);
      end
      tick();
      n_tests++;
      if (valid_b !== 1'b0) begin
         n_fail++;
         $display("FAIL pend_drop_b: got v=%b expected v=0", valid_b);
      end
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      n_tests++;
      if ({busy_a, busy_b} !== 2'b11) begin
         n_fail++;
         $display("FAIL mid_sweep_busy: got %b expected 11", {busy_a, busy_b});
      end
      assert_reset();
      tick();
      tick();
      release_and_count(cycles);
      n_tests++;
      if (cycles != 16) begin
         n_fail++;
         $display("FAIL resweep_len: got %0d cycles expected 16", cycles);
      end
      drive(1'b0, 1'b1, 4'd5, 8'h00, 8'h00, 1'b0);
      tick();
      n_tests++;
      if ({valid_a, dout_a, perr_a} !== {1'b1, 8'h00, 1'b0}) begin
         n_fail++;
         $display("FAIL resweep_a: got v=%b d=%h p=%b expected v=1 d=00 p=0", valid_a, dout_a, perr_a);
      end
      drive(1'b0, 1'b1, 4'd7, 8'h00, 8'h00, 1'b0);
      tick();
      n_tests++;
      if ({valid_b, dout_b, valid_a, dout_a} !== {1'b1, 8'h00, 1'b1, 8'h00}) begin
         n_fail++;
         $display("FAIL resweep_ab: got vb=%b db=%h va=%b da=%h expected 1 00 1 00",
                  valid_b, dout_b, valid_a, dout_a);
      end
      tick();
      n_tests++;
      if ({valid_b, dout_b, perr_b} !== {1'b1, 8'h00, 1'b0}) begin
         n_fail++;
         $display("FAIL resweep_b: got v=%b d=%h p=%b expected v=1 d=00 p=0", valid_b, dout_b, perr_b);
      end
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         drive(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
               AW'($urandom_range(0, 15)), W'($urandom), W'($urandom),
               ($urandom_range(0, 7) == 0));
         tick();
         n_tests++;
         if (valid_a !== exp_a.v || dout_a !== exp_a.d || (exp_a.v && perr_a !== exp_a.p)) begin
            n_fail++;
            $display("FAIL rand_a cycle %0d: got v=%b d=%h p=%b expected v=%b d=%h p=%b",
                     c, valid_a, dout_a, perr_a, exp_a.v, exp_a.d, exp_a.p);
         end
         n_tests++;
         if (valid_b !== exp_b.v || dout_b !== exp_b.d || (exp_b.v && perr_b !== exp_b.p)) begin
            n_fail++;
            $display("FAIL rand_b cycle %0d: got v=%b d=%h p=%b expected v=%b d=%h p=%b",
                     c, valid_b, dout_b, perr_b, exp_b.v, exp_b.d, exp_b.p);
         end
      end
   endtask

   initial begin
      reset_n = 1'b1;
      ce_n = 1'b1; we_n = 1'b1; addr = '0; di = '0; wmask = '0; inject_perr = 1'b0;
      sweep_left = DEPTH;
      cur_a = '0; cur_b = '0; prev_b = '0; exp_a = '0; exp_b = '0;
      test_reset();
      test_clear_read();
      test_write_read();
      test_mask();
      test_rdw();
      test_parity();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/part_sram_sync.md
Name: part_sram_sync

Overview:
- Parametrised, clocked successor to the 4k x 1 static RAM part model.
- Generalised in data width and depth, with per-bit write mask, selectable read latency and read-during-write mode.
- After reset, a sweep state machine clears the whole array; a stored parity bit per word is checked on every read.
- Drop-in storage primitive for CADR memories: SPC, PDL, A/M memories, map RAMs.

Parameters:
- WIDTH, 1, data bits per word (1..64).
- AWIDTH, 12, address bits; depth = 2**AWIDTH.
- RD_LAT, 1, read latency in clocks; legal values 1 or 2.
- WR_THRU, 1, read-during-write to same address: 1 returns new data, 0 returns old data.

Ports:
- clk, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- ce_n, input, 1, chip enable, active low.
- we_n, input, 1, write enable, active low; only qualified by ce_n low.
- addr, input, AWIDTH, word address.
- di, input, WIDTH, write data.
- wmask, input, WIDTH, per-bit write enable; bit=1 writes that bit.
- inject_perr, input, 1, test hook: when high during a write, the stored parity is inverted.
- do, output, WIDTH, read data.
- do_valid, output, 1, one-cycle strobe marking valid do.
- perr, output, 1, parity mismatch on the word presented with do_valid.
- busy, output, 1, clear sweep in progress; accesses are ignored.

Behaviour:
Reset (reset_n low, asynchronous):
- do=0, do_valid=0, perr=0, busy=1.
- Sweep counter = 0 and FSM = CLEAR.
- Array contents are not touched asynchronously.

FSM states:
- CLEAR: each clock writes word[cnt]=0 with parity 0, then cnt+1.
  - At cnt = 2**AWIDTH-1 that word is written, then go to READY.
  - The sweep takes exactly 2**AWIDTH clocks after reset release.
  - busy is high throughout CLEAR and drops on the first READY cycle.
- READY: normal access; busy=0. Remains here until reset.
- Reset asserted mid-sweep or mid-access: the FSM returns to CLEAR with cnt=0 and the sweep restarts. Pipeline registers clear, and any in-flight read produces no do_valid.

Accesses (READY only; ce_n, we_n, addr, di, wmask sampled on the rising edge):
- Write (ce_n=0, we_n=0):
  - For each bit i with wmask[i]=1, word[addr][i] = di[i]; other bits are unchanged.
  - Stored parity = XOR of the resulting full word, XOR inject_perr.
  - wmask=0 leaves data unchanged but still recomputes parity (including injection).
- Read (ce_n=0, we_n=1):
  - RD_LAT=1: do and do_valid are registered on the same edge; valid in the following cycle.
  - RD_LAT=2: one extra register stage.
  - perr = XOR(data) != stored parity, aligned with do_valid.
- Write cycles also produce a read of the same address (read-during-write):
  - do_valid pulses at the normal read latency.
  - WR_THRU=1: do shows the merged new word.
  - WR_THRU=0: do shows the pre-write word.
  - perr reflects the corresponding stored/old parity.
- ce_n=1: no access. do holds its last value and do_valid=0.
- Access attempts while busy=1 are dropped: no write, no do_valid.
- Back-to-back reads every cycle sustain one do_valid per cycle, pipelined in order.
- Address wrap: addr is exactly AWIDTH bits, so no out-of-range access is possible.
- do is never tri-stated; the bus-level tri-state belongs to the wrapper.

Width rules:
- Parity is a single bit over WIDTH bits.
- Array storage is depth x (WIDTH+1).

Test Plan:
1. WIDTH=8, AWIDTH=4: release reset and count clocks until busy falls → busy high exactly 16 cycles. Then read addr 0..15 → all do=0x00, perr=0.
2. RD_LAT=1: write addr 5, di=0xA5, wmask=0xFF. Next cycle read addr 5 → do=0xA5 with do_valid one cycle after the read edge, perr=0. With RD_LAT=2 the strobe arrives one cycle later.
3. Mask: after test 2, write addr 5, di=0x00, wmask=0x0F, then read → do=0xA0, perr=0.
4. Read-during-write: addr 3 holds 0x11; write 0x22 with full mask while reading → WR_THRU=1 gives do=0x22, WR_THRU=0 gives do=0x11. A subsequent read gives 0x22 in both cases.
5. Parity: write addr 7, 0x3C with inject_perr=1, then read → perr=1, do=0x3C. Rewrite with inject_perr=0 and read → perr=0.
6. Pull reset_n low for 2 cycles mid-sweep (cycle 6) and again during a pending RD_LAT=2 read → no do_valid emitted. busy is high again and the full 16-cycle sweep reruns from cnt=0; a prior non-zero word then reads 0x00.
